// File: rtl/prod_accum_stage.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_stage
// Description : Accumulates a programmed number of unsigned multiplier
//               products and returns the sum over a valid/ready handshake.
//               Optional macro ACC_SATURATE_EN: saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module prod_accum_stage #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              busy,
  output logic              overflow
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_accum = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_remaining;
  logic             r_overflow;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_accept;

  // One extra bit captures the carry out of the accumulator.
  assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign w_carry = w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once at all-ones any nonzero product carries again, so saturation holds.
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  assign w_accept  = in_valid && (r_state == c_accum);

  assign in_ready  = (r_state == c_accum);
  assign out_valid = (r_state == c_done);
  assign busy      = (r_state != c_idle);
  assign out_acc   = r_acc;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_acc       <= '0;
      r_remaining <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            if (len != '0) begin
              r_remaining <= len;
              r_state     <= c_accum;
            end else begin
              r_state <= c_done;
            end
          end
        end
        c_accum: begin
          if (w_accept) begin
            r_acc       <= w_acc_next;
            r_remaining <= r_remaining - LEN_W'(1);
            if (w_carry) begin
              r_overflow <= 1'b1;
            end
            if (r_remaining == LEN_W'(1)) begin
              r_state <= c_done;
            end
          end
        end
        c_done: begin
          if (out_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prod_accum_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_prod_accum_stage
// Description : Scoreboard bench for prod_accum_stage (ACC_W=10 so wrap and
//               saturation are reachable with 8-bit products).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prod_accum_stage;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_acc;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int exp_acc_q[$];
  int exp_ovf_q[$];

  prod_accum_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: running sum with plain integer arithmetic.
  function automatic int model(input int prods[$], output int ovf);
    int acc = 0;
    int lim = 1 << ACC_W;
    ovf = 0;
    foreach (prods[i]) begin
      acc = acc + prods[i];
      if (acc >= lim) begin
        ovf = 1;
`ifdef ACC_SATURATE_EN
        acc = lim - 1;
`else
        acc = acc - lim;
`endif
      end
    end
    return acc;
  endfunction

  // Monitor: every result handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_acc_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("result_acc", int'(out_acc), exp_acc_q.pop_front());
        chk("result_ovf", int'(overflow), exp_ovf_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // bubble: 0 none, 1 alternate (bubble first), 2 random
  task automatic run_job(input int l, input int prods[$], input int bubble,
                         input int delay, input bit pulse_start);
    int accepted = 0;
    int e_acc;
    int e_ovf;
    bit bub;
    bit tog = 1'b1;
    start = 1'b1;
    len   = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    while (accepted < l) begin
      if (bubble == 1)      bub = tog;
      else if (bubble == 2) bub = ($urandom_range(0, 3) == 0);
      else                  bub = 1'b0;
      tog = ~tog;
      if (bub) begin
        in_valid = 1'b0;
        in_prod  = PROD_W'($urandom_range(0, 255));
      end else begin
        in_valid = 1'b1;
        in_prod  = PROD_W'(prods[accepted]);
      end
      chk("in_ready_accum", int'(in_ready), 1);
      chk("no_early_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      if (!bub) accepted++;
    end
    in_valid = 1'b0;
    e_acc = model(prods, e_ovf);
    exp_acc_q.push_back(e_acc);
    exp_ovf_q.push_back(e_ovf);
    chk("out_valid_latency", int'(out_valid), 1);
    chk("in_ready_done", int'(in_ready), 0);
    for (int d = 0; d < delay; d++) begin
      if (pulse_start && d == 1) begin
        start = 1'b1;
        len   = LEN_W'(3);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_acc", int'(out_acc), e_acc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_busy", int'(busy), 0);
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_in_ready", int'(in_ready), 0);
  endtask

  initial begin
    int q[$];
    int l;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    q = '{225, 225, 225};
    run_job(3, q, 0, 0, 1'b0);
    q = '{6, 0, 9, 1};
    run_job(4, q, 1, 0, 1'b0);
    q = '{10, 20};
    run_job(2, q, 0, 5, 1'b1);
    q = '{225, 225, 225, 225, 225};
    run_job(5, q, 0, 1, 1'b0);
    q = {};
    run_job(0, q, 0, 2, 1'b0);

    // Mid-job reset discards the partial sum.
    start = 1'b1;
    len   = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_prod  = PROD_W'(50);
    @(posedge clk); #1;
    in_prod  = PROD_W'(60);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_acc", int'(out_acc), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q = '{7};
    run_job(1, q, 0, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      l = (j == 0) ? 40 : $urandom_range(1, 8);
      q = {};
      for (int k = 0; k < l; k++) q.push_back($urandom_range(0, 225));
      run_job(l, q, 2, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_acc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prod_accum_stage.md
Name: prod_accum_stage

Overview:
- Sequential stage directly downstream of the combinational 4x4 array multiplier.
- Consumes a stream of 8-bit products over a valid/ready handshake and accumulates a programmed number of them into a wide accumulator.
- Presents the final sum with a valid/ready output handshake.
- Used to build dot-product and MAC datapaths around the unsigned multiplier tree.

Parameters:
- PROD_W, 8, product width (multiplier output o[7:0]).
- ACC_W, 16, accumulator/result width; must be >= PROD_W.
- LEN_W, 8, width of the product-count field.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- len  in  LEN_W  number of products to accumulate; sampled with start.
- in_valid  in  1  upstream product valid.
- in_ready  out  1  stage accepts a product this cycle.
- in_prod  in  PROD_W  unsigned product from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  accumulated sum.
- busy  out  1  high in ACCUM or DONE.
- overflow  out  1  sticky: a carry/wrap occurred in the current job.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, acc=0, remaining=0, overflow=0. Outputs in_ready=0, out_valid=0, out_acc=0, busy=0.
- State machine (registered): IDLE, ACCUM, DONE.
- IDLE:
  - start=1 with len!=0: acc<=0, overflow<=0, remaining<=len, go to ACCUM.
  - start=1 with len==0: acc<=0, overflow<=0, go to DONE.
  - start=0: stay.
- ACCUM:
  - in_ready=1, decoded from the state register only (no combinational path from in_valid or out_ready).
  - On in_valid&&in_ready: acc <= acc + zero-extended in_prod; remaining <= remaining-1.
  - If remaining==1 at acceptance, go to DONE.
  - in_valid=0 cycles are bubbles: no change.
- DONE:
  - out_valid=1; out_acc holds the final sum, stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE next cycle.
- out_acc mirrors the acc register in all states. It is meaningful only while out_valid=1.
- Latency:
  - start accepted at edge T: in_ready=1 from the cycle after T.
  - Last product accepted at edge T: out_valid=1 from the cycle after T.
  - Throughput: one product per cycle.
- Arithmetic: unsigned. Sum computed at ACC_W+1 bits. A carry into bit ACC_W sets overflow (sticky until next start) and the result wraps modulo 2^ACC_W.
- start outside IDLE is ignored. len is not re-sampled mid-job.
- Back-to-back jobs: start may be asserted in the first IDLE cycle after the result handshake. There is no overlap of jobs.
- busy = (state!=IDLE).
- Reset asserted mid-job: immediate return to reset values. The partial sum is discarded and no out_valid is produced.

Optional Feature:
- ACC_SATURATE_EN
  - Defined: on carry out, acc saturates to all-ones (2^ACC_W-1) and holds there for the rest of the job; overflow is still set.
  - Undefined: modulo wrap as described above.

Test Plan:
- len=3; products 225,225,225 with in_valid held high -> out_valid exactly one cycle after the 3rd acceptance; out_acc=675; overflow=0.
- len=4; products 6,0,9,1 with in_valid low on alternate cycles -> in_ready stays high; bubbles ignored; out_acc=16 after the 4th accepted product only.
- len=2; products 10,20; out_ready held low 5 cycles -> out_valid and out_acc=30 stable all 5 cycles; IDLE on the cycle after out_ready=1; start pulsed during DONE ignored.
- ACC_W=10; len=5 of 225 -> without macro out_acc=101, overflow=1; with ACC_SATURATE_EN out_acc=1023, overflow=1.
- start with len=0 -> out_valid next cycle with out_acc=0, overflow=0; no product accepted (in_ready never high).
- len=4; rst_n low after 2 accepted products -> in_ready=0, busy=0, out_valid=0, out_acc=0 immediately. A new job len=1, product 7 after reset -> out_acc=7.
